apb_regif: RTL and testbench
============================

APB_REGIF -- requirements
Module: apb_regif

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data and channel data width.
REQ-003 SHALL have parameter N_CH, default 2, number of Tx/Rx channels (1..2**ADDR_W-1).
REQ-004 SHALL have parameter WAIT_CYC, default 0, wait states inserted per access (0..15).
REQ-005 i_Pclk  in  1  sole clock, all logic on rising edge.
REQ-006 i_Rst  in  1  reset, synchronous, active-high.
REQ-007 i_Paddr  in  ADDR_W  APB address.
REQ-008 i_Psel / i_Penable / i_Pwrite  in  1 each  APB select, enable, write.
REQ-009 i_Pwdata  in  DATA_W  APB write data.
REQ-010 o_Prdata  out  DATA_W  APB read data.
REQ-011 o_Pready / o_Pslverr  out  1 each  APB ready, slave error.
REQ-012 o_Tx_En / o_Rx_En  out  N_CH each  per-channel one-cycle strobes.
REQ-013 o_Tx_Data  out  DATA_W  write data for the strobed Tx channel.
REQ-014 i_Rx_Data  in  N_CH*DATA_W  per-channel receive data, channel c in bits [c*DATA_W +: DATA_W].

Function
REQ-015 Address map: 0..N_CH-1 = channel c data; N_CH = CTRL register (bit c = channel c enable, upper bits read 0); all others unmapped.
REQ-016 FSM states: IDLE, SETUP, ACCESS.
- IDLE->SETUP on Psel & !Penable.
- SETUP->ACCESS on Psel & Penable; else to IDLE.
- ACCESS->IDLE on completion or abort.
REQ-017 Address, Pwrite and Pwdata latch on the IDLE->SETUP edge.
REQ-018 Wait counter clears entering ACCESS; o_Pready = 1 only in ACCESS with counter == WAIT_CYC. Latency: WAIT_CYC+1 ACCESS cycles.
REQ-019 Completion: rising edge with state ACCESS, Psel, Penable and o_Pready all high.
REQ-020 Abort: Psel or Penable low in ACCESS before completion -> IDLE, no strobe, no register update.
REQ-021 Psel & Penable high while in IDLE (setup phase missing) is ignored; FSM stays IDLE.
REQ-022 o_Pslverr asserts with o_Pready in these cases:
- unmapped address;
- data access to a channel whose CTRL bit is 0.
REQ-023 No strobe or register update on an errored transfer.
REQ-024 Write completion to channel c: o_Tx_En[c] high for exactly the next cycle; o_Tx_Data holds latched Pwdata in that cycle.
REQ-025 Read of channel c: o_Prdata = i_Rx_Data slice c while o_Pready is high; o_Rx_En[c] high for exactly the cycle after completion.
REQ-026 Read of CTRL returns the enable bits, zero-extended; write updates them on completion.
REQ-027 At most one bit of o_Tx_En | o_Rx_En is high in any cycle.
REQ-028 o_Prdata = 0 whenever o_Pready is low or the access is a write.
REQ-029 Back-to-back transfers: IDLE->SETUP is taken in the cycle after completion, giving a minimum 3-cycle transfer period at WAIT_CYC=0.

Reset
REQ-030 i_Rst forces IDLE, wait counter 0, CTRL all ones; o_Tx_En, o_Rx_En, o_Pready, o_Pslverr, o_Prdata and o_Tx_Data all 0.
REQ-031 Reset mid-transfer drops it with no strobe; reset has priority over every other event.

Structure
REQ-032 FSM state encoding and the CTRL address-offset rule SHALL live in shared package apb_pkg.
REQ-033 Wait-state counter SHALL be sub-module apb_wait_cnt (clear, enable, terminal-count output).

Verification
REQ-034 N_CH=2, WAIT_CYC=0: write 0xA5 to addr 1 -> o_Pready in first ACCESS cycle, o_Tx_En=2'b10 for one cycle, o_Tx_Data=0xA5.
REQ-035 WAIT_CYC=3, read addr 0 with i_Rx_Data slice 0=0x3C -> Pready low 3 cycles, then Prdata=0x3C, then o_Rx_En=2'b01 for one cycle.
REQ-036 Write 0x01 to CTRL (addr 2), then write addr 1 -> Pslverr=1, no Tx strobe; read CTRL -> 0x01.
REQ-037 Access addr 7 -> Pslverr=1 with Pready, all strobes 0.
REQ-038 WAIT_CYC=2, drop Penable in second ACCESS cycle -> IDLE, no strobe; next valid write completes normally.
REQ-039 Assert i_Rst in ACCESS -> next cycle all outputs 0, CTRL=all ones, FSM IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and register-map helpers for the APB register interface
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    localparam int CNT_W = 4;
    function automatic int ctrl_addr(input int n_ch);
        return n_ch;
    endfunction
endpackage

// File: rtl/apb_regif_if.sv
// apb_regif_if: APB completer bus bundle
interface apb_regif_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] i_Paddr;
    logic              i_Psel;
    logic              i_Penable;
    logic              i_Pwrite;
    logic [DATA_W-1:0] i_Pwdata;
    logic [DATA_W-1:0] o_Prdata;
    logic              o_Pready;
    logic              o_Pslverr;
    modport master (output i_Paddr, i_Psel, i_Penable, i_Pwrite, i_Pwdata, input o_Prdata, o_Pready, o_Pslverr);
    modport slave (input i_Paddr, i_Psel, i_Penable, i_Pwrite, i_Pwdata, output o_Prdata, o_Pready, o_Pslverr);
endinterface

// File: rtl/apb_wait_cnt.sv
// apb_wait_cnt: wait-state counter with clear, enable and terminal-count flag
module apb_wait_cnt import apb_pkg::*; #(
    parameter int TC = 0
) (
    input  logic i_Pclk,
    input  logic i_Rst,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Done
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge i_Pclk) begin
        if (i_Rst || i_Clr) cnt <= '0;
        else if (i_En) cnt <= cnt + CNT_W'(1);
    end
    assign o_Done = cnt == CNT_W'(TC);
endmodule

// File: rtl/apb_regif.sv
// apb_regif: APB register interface fanning out to per-channel Tx/Rx strobes with CTRL enables
module apb_regif import apb_pkg::*; #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int N_CH     = 2,
    parameter int WAIT_CYC = 0
) (
    input  logic                   i_Pclk,
    input  logic                   i_Rst,
    apb_regif_if.slave             apb,
    output logic [N_CH-1:0]        o_Tx_En,
    output logic [N_CH-1:0]        o_Rx_En,
    output logic [DATA_W-1:0]      o_Tx_Data,
    input  logic [N_CH*DATA_W-1:0] i_Rx_Data
);
    apb_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [N_CH-1:0]   ctrl;
    logic [N_CH-1:0]   ch_oh;
    logic [DATA_W-1:0] rd_ch;
    logic              enter, done, is_chan, is_ctrl, err, bus_on;

    assign bus_on = apb.i_Psel && apb.i_Penable;
    assign enter  = state == SETUP && bus_on;

    apb_wait_cnt #(.TC(WAIT_CYC)) u_wait (
        .i_Pclk (i_Pclk),
        .i_Rst  (i_Rst),
        .i_Clr  (enter),
        .i_En   (state == ACCESS && !done),
        .o_Done (done)
    );

    always_comb begin
        is_ctrl = addr == ADDR_W'(ctrl_addr(N_CH));
        is_chan = addr < ADDR_W'(N_CH);
        ch_oh   = is_chan ? N_CH'(1) << addr : '0;
        err     = !(is_chan || is_ctrl) || (is_chan && (ctrl & ch_oh) == '0);
        rd_ch   = '0;
        for (int c = 0; c < N_CH; c++)
            if (addr == ADDR_W'(c)) rd_ch = i_Rx_Data[c*DATA_W +: DATA_W];
        apb.o_Pready  = state == ACCESS && done;
        apb.o_Pslverr = apb.o_Pready && err;
        apb.o_Prdata  = (apb.o_Pready && !write && !err) ? (is_ctrl ? DATA_W'(ctrl) : rd_ch) : '0;
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            state     <= IDLE;
            addr      <= '0;
            write     <= 1'b0;
            wdata     <= '0;
            ctrl      <= '1;
            o_Tx_En   <= '0;
            o_Rx_En   <= '0;
            o_Tx_Data <= '0;
        end else begin
            o_Tx_En <= '0;
            o_Rx_En <= '0;
            case (state)
                IDLE: if (apb.i_Psel && !apb.i_Penable) begin
                    state <= SETUP;
                    addr  <= apb.i_Paddr;
                    write <= apb.i_Pwrite;
                    wdata <= apb.i_Pwdata;
                end
                SETUP: state <= bus_on ? ACCESS : IDLE;
                ACCESS: if (!bus_on) state <= IDLE;
                else if (apb.o_Pready) begin
                    state <= IDLE;
                    if (!err && write && is_ctrl) ctrl <= N_CH'(wdata);
                    if (!err && write && is_chan) begin
                        o_Tx_En   <= ch_oh;
                        o_Tx_Data <= wdata;
                    end
                    if (!err && !write && is_chan) o_Rx_En <= ch_oh;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_regif.sv
// tb_apb_regif: scoreboard bench driving a WAIT_CYC=0 and a WAIT_CYC=3 instance
module tb_apb_regif;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[2];
    logic [3:0] paddr[2];
    logic       psel[2], penable[2], pwrite[2];
    logic [7:0] pwdata[2];
    logic [7:0] prdata[2];
    logic       pready[2], pslverr[2];
    logic [1:0] tx_en[2], rx_en[2];
    logic [7:0] tx_data[2];
    logic [15:0] rx_data[2];

    apb_regif_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
    apb_regif_if #(.ADDR_W(4), .DATA_W(8)) b1 ();

    assign b0.i_Paddr = paddr[0];
    assign b0.i_Psel = psel[0];
    assign b0.i_Penable = penable[0];
    assign b0.i_Pwrite = pwrite[0];
    assign b0.i_Pwdata = pwdata[0];
    assign prdata[0] = b0.o_Prdata;
    assign pready[0] = b0.o_Pready;
    assign pslverr[0] = b0.o_Pslverr;
    assign b1.i_Paddr = paddr[1];
    assign b1.i_Psel = psel[1];
    assign b1.i_Penable = penable[1];
    assign b1.i_Pwrite = pwrite[1];
    assign b1.i_Pwdata = pwdata[1];
    assign prdata[1] = b1.o_Prdata;
    assign pready[1] = b1.o_Pready;
    assign pslverr[1] = b1.o_Pslverr;

    apb_regif #(.ADDR_W(4), .DATA_W(8), .N_CH(2), .WAIT_CYC(0)) u0 (
        .i_Pclk(clk), .i_Rst(rst[0]), .apb(b0),
        .o_Tx_En(tx_en[0]), .o_Rx_En(rx_en[0]), .o_Tx_Data(tx_data[0]), .i_Rx_Data(rx_data[0])
    );
    apb_regif #(.ADDR_W(4), .DATA_W(8), .N_CH(2), .WAIT_CYC(3)) u1 (
        .i_Pclk(clk), .i_Rst(rst[1]), .apb(b1),
        .o_Tx_En(tx_en[1]), .o_Rx_En(rx_en[1]), .o_Tx_Data(tx_data[1]), .i_Rx_Data(rx_data[1])
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic [1:0] tx;
        logic [1:0] rx;
        logic [7:0] txd;
        int         waits;
    } exp_t;

    exp_t q[2][$];
    exp_t pe[2];
    exp_t e;
    bit   pend[2];
    int   wcnt[2];
    int   zreq[2];
    int   zack[2];
    bit   done = 1'b0;
    int   n = 0;
    int   bad = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pend[k]) begin
                n++;
                if ({tx_en[k], rx_en[k]} !== {pe[k].tx, pe[k].rx}) begin
                    bad++;
                    $display("FAIL strobe dut%0d: got tx=%b rx=%b, want tx=%b rx=%b", k, tx_en[k], rx_en[k], pe[k].tx, pe[k].rx);
                end
                if (pe[k].tx != 2'b00) begin
                    n++;
                    if (tx_data[k] !== pe[k].txd) begin
                        bad++;
                        $display("FAIL tx_data dut%0d: got %h, want %h", k, tx_data[k], pe[k].txd);
                    end
                end
                pend[k] = 1'b0;
            end else if ((tx_en[k] | rx_en[k]) != 2'b00) begin
                n++;
                bad++;
                $display("FAIL stray_strobe dut%0d: got tx=%b rx=%b, want 00 00", k, tx_en[k], rx_en[k]);
            end
            if (!pready[k] && (prdata[k] != 8'h00 || pslverr[k])) begin
                n++;
                bad++;
                $display("FAIL idle_out dut%0d: got prdata=%h slverr=%b, want 00 0", k, prdata[k], pslverr[k]);
            end
            if (zreq[k] != zack[k]) begin
                n++;
                if ({prdata[k], pready[k], pslverr[k], tx_en[k], rx_en[k], tx_data[k]} !== 22'h0) begin
                    bad++;
                    $display("FAIL zero_out dut%0d: got prdata=%h rdy=%b err=%b tx=%b rx=%b txd=%h, want all 0",
                             k, prdata[k], pready[k], pslverr[k], tx_en[k], rx_en[k], tx_data[k]);
                end
                zack[k] = zreq[k];
            end
            if (psel[k] && penable[k] && pready[k]) begin
                if (q[k].size() == 0) begin
                    n++;
                    bad++;
                    $display("FAIL unexpected_ready dut%0d: got completion, want none", k);
                end else begin
                    e = q[k].pop_front();
                    n += 3;
                    if (prdata[k] !== e.rdata) begin
                        bad++;
                        $display("FAIL prdata dut%0d: got %h, want %h", k, prdata[k], e.rdata);
                    end
                    if (pslverr[k] !== e.err) begin
                        bad++;
                        $display("FAIL pslverr dut%0d: got %b, want %b", k, pslverr[k], e.err);
                    end
                    if (wcnt[k] != e.waits) begin
                        bad++;
                        $display("FAIL latency dut%0d: got %0d wait cycles, want %0d", k, wcnt[k], e.waits);
                    end
                    pe[k] = e;
                    pend[k] = 1'b1;
                end
                wcnt[k] = 0;
            end else wcnt[k] = (psel[k] && penable[k]) ? wcnt[k] + 1 : 0;
        end
        if (done) begin
            for (int k = 0; k < 2; k++) begin
                n++;
                if (q[k].size() != 0) begin
                    bad++;
                    $display("FAIL leftover dut%0d: got %0d pending, want 0", k, q[k].size());
                end
            end
            $display("== %0d vectors applied, %0d miscompares ==", n, bad);
            $finish;
        end
    end

    task automatic xfer(input int k, input logic [3:0] a, input logic w, input logic [7:0] d,
                        input logic [7:0] rd, input logic er, input logic [1:0] tx, input logic [1:0] rx);
        exp_t x;
        x.rdata = rd;
        x.err = er;
        x.tx = tx;
        x.rx = rx;
        x.txd = d;
        x.waits = (k == 1 ? 3 : 0) + 1;
        q[k].push_back(x);
        paddr[k] = a;
        pwrite[k] = w;
        pwdata[k] = d;
        psel[k] = 1'b1;
        penable[k] = 1'b0;
        @(posedge clk);
        #1 penable[k] = 1'b1;
        for (int i = 0; i <= 60; i++) begin
            @(negedge clk);
            if (pready[k]) break;
            if (i == 60) begin
                $display("FAIL timeout dut%0d: got no pready, want pready within 60 cycles", k);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1 psel[k] = 1'b0;
        penable[k] = 1'b0;
    endtask

    task automatic start(input int k, input logic [3:0] a, input logic [7:0] d);
        paddr[k] = a;
        pwrite[k] = 1'b1;
        pwdata[k] = d;
        psel[k] = 1'b1;
        penable[k] = 1'b0;
        @(posedge clk);
        #1 penable[k] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            psel[k] = 1'b0;
            penable[k] = 1'b0;
            pwrite[k] = 1'b0;
            paddr[k] = 4'h0;
            pwdata[k] = 8'h00;
        end
        rx_data[0] = 16'h5A11;
        rx_data[1] = 16'hC33C;
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0;
        rst[1] = 1'b0;
        zreq[0]++;
        zreq[1]++;
        psel[0] = 1'b1;
        penable[0] = 1'b1;
        paddr[0] = 4'h1;
        pwrite[0] = 1'b1;
        pwdata[0] = 8'hEE;
        repeat (3) @(posedge clk);
        #1 zreq[0]++;
        psel[0] = 1'b0;
        penable[0] = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 4'h1, 1'b1, 8'hA5, 8'h00, 1'b0, 2'b10, 2'b00);
        xfer(0, 4'h0, 1'b0, 8'h00, 8'h11, 1'b0, 2'b00, 2'b01);
        xfer(0, 4'h1, 1'b0, 8'h00, 8'h5A, 1'b0, 2'b00, 2'b10);
        xfer(0, 4'h2, 1'b0, 8'h00, 8'h03, 1'b0, 2'b00, 2'b00);
        xfer(0, 4'h2, 1'b1, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00);
        xfer(0, 4'h1, 1'b1, 8'h77, 8'h00, 1'b1, 2'b00, 2'b00);
        xfer(0, 4'h2, 1'b0, 8'h00, 8'h01, 1'b0, 2'b00, 2'b00);
        xfer(0, 4'h0, 1'b1, 8'h3E, 8'h00, 1'b0, 2'b01, 2'b00);
        xfer(0, 4'h7, 1'b1, 8'hFF, 8'h00, 1'b1, 2'b00, 2'b00);
        xfer(0, 4'h3, 1'b1, 8'h55, 8'h00, 1'b1, 2'b00, 2'b00);
        xfer(0, 4'h2, 1'b1, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b00);
        xfer(0, 4'h2, 1'b0, 8'h00, 8'h03, 1'b0, 2'b00, 2'b00);
        xfer(0, 4'h1, 1'b0, 8'h00, 8'h5A, 1'b0, 2'b00, 2'b10);
        xfer(1, 4'h0, 1'b0, 8'h00, 8'h3C, 1'b0, 2'b00, 2'b01);
        xfer(1, 4'h1, 1'b1, 8'h5E, 8'h00, 1'b0, 2'b10, 2'b00);
        start(1, 4'h0, 8'h99);
        @(posedge clk);
        #1 psel[1] = 1'b0;
        penable[1] = 1'b0;
        @(posedge clk);
        #1;
        xfer(1, 4'h0, 1'b1, 8'h42, 8'h00, 1'b0, 2'b01, 2'b00);
        xfer(1, 4'h2, 1'b1, 8'h02, 8'h00, 1'b0, 2'b00, 2'b00);
        xfer(1, 4'h0, 1'b1, 8'h13, 8'h00, 1'b1, 2'b00, 2'b00);
        xfer(1, 4'h1, 1'b0, 8'h00, 8'hC3, 1'b0, 2'b00, 2'b10);
        start(1, 4'h1, 8'h66);
        rst[1] = 1'b1;
        psel[1] = 1'b0;
        penable[1] = 1'b0;
        @(posedge clk);
        #1 rst[1] = 1'b0;
        zreq[1]++;
        xfer(1, 4'h2, 1'b0, 8'h00, 8'h03, 1'b0, 2'b00, 2'b00);
        xfer(1, 4'h0, 1'b0, 8'h00, 8'h3C, 1'b0, 2'b00, 2'b01);
        repeat (4) @(posedge clk);
        #1 done = 1'b1;
    end
endmodule
